// File: rtl/rv_trigger_unit.sv
// Hardware trigger unit: N address/data match triggers with chaining plus one
// instruction-count trigger, configured through tselect/tdata1/tdata2/tinfo.
module rv_trigger_unit #(
  parameter int unsigned NumTriggers = 4,
  parameter int unsigned Width       = 32,
  parameter int unsigned CountWidth  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      csr_addr,
  input  logic [Width-1:0] csr_wdata,
  input  logic             csr_write,
  output logic [Width-1:0] csr_rdata,
  output logic             csr_sel,
  input  logic             debug_mode,
  input  logic [Width-1:0] pc,
  input  logic             pc_valid,
  input  logic [Width-1:0] mem_addr,
  input  logic             mem_load,
  input  logic             mem_store,
  input  logic             retire,
  output logic             breakpoint,
  output logic             debug_req,
  output logic [3:0]       hit_idx
);

  localparam int unsigned N = NumTriggers;
  localparam logic [11:0] AddrTselect = 12'h7A0;
  localparam logic [11:0] AddrTdata1  = 12'h7A1;
  localparam logic [11:0] AddrTdata2  = 12'h7A2;
  localparam logic [11:0] AddrTinfo   = 12'h7A4;
  localparam logic [3:0]  IcIdx       = 4'(NumTriggers);

  typedef enum logic [1:0] {
    MatchEq = 2'd0,
    MatchGe = 2'd2,
    MatchLt = 2'd3
  } match_e;

  logic [3:0]       tselect_q, tselect_d;
  logic [N-1:0]     type_q, type_d, dmode_q, dmode_d, hit_q, hit_d;
  logic [N-1:0]     action_q, action_d, chain_q, chain_d;
  logic [N-1:0]     exe_q, exe_d, st_q, st_d, ld_q, ld_d;
  match_e           match_q [N];
  match_e           match_d [N];
  logic [Width-1:0] tdata2_q [N];
  logic [Width-1:0] tdata2_d [N];

  logic                  ic_dmode_q, ic_dmode_d, ic_hit_q, ic_hit_d;
  logic                  ic_action_q, ic_action_d, ic_pending_q, ic_pending_d;
  logic [CountWidth-1:0] ic_count_q, ic_count_d;

  logic [N-1:0] sel_vec;
  logic         sel_icount, sel_dmode, wr_ok;
  logic         wr_tsel, wr_t1, wr_t2, wr_ic;
  logic [N-1:0] fire;
  logic         ic_fire;

  logic   w_type2, w_dmode, w_hit, w_action, w_chain, w_exe, w_st, w_ld;
  logic   w_ic_hit, w_ic_action;
  match_e w_match;

  function automatic logic addr_cmp(input logic [Width-1:0] a,
                                    input logic [Width-1:0] t,
                                    input match_e m);
    logic r;
    case (m)
      MatchGe: r = (a >= t);
      MatchLt: r = (a < t);
      default: r = (a == t);
    endcase
    return r;
  endfunction

  // ---------------- CSR decode and write-field sanitation ----------------
  always_comb begin
    sel_vec    = '0;
    sel_icount = (tselect_q == IcIdx);
    sel_dmode  = sel_icount & ic_dmode_q;
    for (int unsigned i = 0; i < N; i++) begin
      sel_vec[i] = (tselect_q == 4'(i));
      if (sel_vec[i] && dmode_q[i]) sel_dmode = 1'b1;
    end
  end

  // A trigger owned by the debugger is locked against writes from normal mode.
  assign wr_ok   = ~sel_dmode | debug_mode;
  assign wr_tsel = csr_write & (csr_addr == AddrTselect);
  assign wr_t1   = csr_write & (csr_addr == AddrTdata1) & wr_ok;
  assign wr_t2   = csr_write & (csr_addr == AddrTdata2) & wr_ok;
  assign wr_ic   = wr_t1 & sel_icount;

  assign w_type2     = (csr_wdata[31:28] == 4'd2);
  assign w_dmode     = csr_wdata[27] & debug_mode;
  assign w_hit       = csr_wdata[20];
  assign w_action    = (csr_wdata[15:12] == 4'd1);
  assign w_chain     = csr_wdata[11];
  assign w_exe       = csr_wdata[2];
  assign w_st        = csr_wdata[1];
  assign w_ld        = csr_wdata[0];
  assign w_ic_hit    = csr_wdata[24];
  assign w_ic_action = (csr_wdata[5:0] == 6'd1);

  always_comb begin
    case (csr_wdata[10:7])
      4'd2:    w_match = MatchGe;
      4'd3:    w_match = MatchLt;
      default: w_match = MatchEq;
    endcase
  end

  // ---------------- Match and chain evaluation ----------------
  // prev_ok carries "the chain leading into trigger i is satisfied".
  always_comb begin : match_eval
    logic prev_ok;
    logic m;
    logic qual;
    fire    = '0;
    prev_ok = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      m = type_q[i] & (
            (exe_q[i] & pc_valid  & addr_cmp(pc,       tdata2_q[i], match_q[i])) |
            (ld_q[i]  & mem_load  & addr_cmp(mem_addr, tdata2_q[i], match_q[i])) |
            (st_q[i]  & mem_store & addr_cmp(mem_addr, tdata2_q[i], match_q[i])));
      qual    = m & prev_ok;
      fire[i] = qual & ~chain_q[i] & ~debug_mode;
      prev_ok = chain_q[i] ? qual : 1'b1;
    end
  end

  assign ic_fire = ic_pending_q & pc_valid & ~debug_mode;

  // ---------------- Priority: lowest index wins ----------------
  always_comb begin : prio
    logic       found;
    logic       act;
    logic [3:0] idx;
    found = 1'b0;
    act   = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (fire[i] && !found) begin
        found = 1'b1;
        act   = action_q[i];
        idx   = 4'(i);
      end
    end
    if (ic_fire && !found) begin
      found = 1'b1;
      act   = ic_action_q;
      idx   = IcIdx;
    end
    breakpoint = found & ~act;
    debug_req  = found & act;
    hit_idx    = idx;
  end

  // ---------------- Next state ----------------
  always_comb begin
    tselect_d = tselect_q;
    if (wr_tsel && (csr_wdata <= Width'(N))) tselect_d = csr_wdata[3:0];

    type_d   = type_q;
    dmode_d  = dmode_q;
    hit_d    = hit_q;
    action_d = action_q;
    chain_d  = chain_q;
    exe_d    = exe_q;
    st_d     = st_q;
    ld_d     = ld_q;
    match_d  = match_q;
    tdata2_d = tdata2_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_t1 && sel_vec[i]) begin
        type_d[i]   = w_type2;
        dmode_d[i]  = w_dmode;
        hit_d[i]    = w_hit;
        action_d[i] = w_action;
        chain_d[i]  = w_chain && (i != N - 1);
        match_d[i]  = w_match;
        exe_d[i]    = w_exe;
        st_d[i]     = w_st;
        ld_d[i]     = w_ld;
      end
      if (wr_t2 && sel_vec[i]) tdata2_d[i] = csr_wdata;
      if (fire[i]) hit_d[i] = 1'b1;
    end

    ic_dmode_d   = ic_dmode_q;
    ic_hit_d     = ic_hit_q;
    ic_action_d  = ic_action_q;
    ic_count_d   = ic_count_q;
    ic_pending_d = ic_pending_q;
    if (ic_fire) ic_pending_d = 1'b0;
    if (retire && !debug_mode && (ic_count_q != '0)) begin
      ic_count_d = ic_count_q - CountWidth'(1);
      if (ic_count_q == CountWidth'(1)) ic_pending_d = 1'b1;
    end
    // A reprogramming write overrides a coincident retire.
    if (wr_ic) begin
      ic_dmode_d   = w_dmode;
      ic_hit_d     = w_ic_hit;
      ic_action_d  = w_ic_action;
      ic_count_d   = csr_wdata[CountWidth+9:10];
      ic_pending_d = 1'b0;
    end
    if (ic_fire) ic_hit_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tselect_q    <= '0;
      type_q       <= '0;
      dmode_q      <= '0;
      hit_q        <= '0;
      action_q     <= '0;
      chain_q      <= '0;
      exe_q        <= '0;
      st_q         <= '0;
      ld_q         <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        match_q[i]  <= MatchEq;
        tdata2_q[i] <= '0;
      end
      ic_dmode_q   <= 1'b0;
      ic_hit_q     <= 1'b0;
      ic_action_q  <= 1'b0;
      ic_count_q   <= '0;
      ic_pending_q <= 1'b0;
    end else begin
      tselect_q    <= tselect_d;
      type_q       <= type_d;
      dmode_q      <= dmode_d;
      hit_q        <= hit_d;
      action_q     <= action_d;
      chain_q      <= chain_d;
      exe_q        <= exe_d;
      st_q         <= st_d;
      ld_q         <= ld_d;
      match_q      <= match_d;
      tdata2_q     <= tdata2_d;
      ic_dmode_q   <= ic_dmode_d;
      ic_hit_q     <= ic_hit_d;
      ic_action_q  <= ic_action_d;
      ic_count_q   <= ic_count_d;
      ic_pending_q <= ic_pending_d;
    end
  end

  // ---------------- CSR read ----------------
  assign csr_sel = (csr_addr == AddrTselect) | (csr_addr == AddrTdata1) |
                   (csr_addr == AddrTdata2)  | (csr_addr == AddrTinfo);

  always_comb begin : rd_mux
    logic [Width-1:0] t1;
    logic [Width-1:0] t2;
    t1 = '0;
    t2 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_vec[i]) begin
        t1[31:28] = type_q[i] ? 4'd2 : 4'd0;
        t1[27]    = dmode_q[i];
        t1[20]    = hit_q[i];
        t1[12]    = action_q[i];
        t1[11]    = chain_q[i];
        t1[8:7]   = match_q[i];
        t1[2]     = exe_q[i];
        t1[1]     = st_q[i];
        t1[0]     = ld_q[i];
        t2        = tdata2_q[i];
      end
    end
    if (sel_icount) begin
      t1[31:28]           = 4'd3;
      t1[27]              = ic_dmode_q;
      t1[24]              = ic_hit_q;
      t1[CountWidth+9:10] = ic_count_q;
      t1[0]               = ic_action_q;
    end
    case (csr_addr)
      AddrTselect: csr_rdata = Width'(tselect_q);
      AddrTdata1:  csr_rdata = t1;
      AddrTdata2:  csr_rdata = t2;
      AddrTinfo:   csr_rdata = Width'(32'h0000_000C);
      default:     csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rv_trigger_unit.sv
// Directed-vector bench for rv_trigger_unit with hand-computed expectations.
module tb_rv_trigger_unit;

  localparam logic [11:0] A_TSEL = 12'h7A0;
  localparam logic [11:0] A_TD1  = 12'h7A1;
  localparam logic [11:0] A_TD2  = 12'h7A2;
  localparam logic [11:0] A_TINF = 12'h7A4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic [31:0] csr_rdata;
  logic        csr_sel;
  logic        debug_mode;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] mem_addr;
  logic        mem_load;
  logic        mem_store;
  logic        retire;
  logic        breakpoint;
  logic        debug_req;
  logic [3:0]  hit_idx;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;
  logic [5:0]  fv;

  always #5 clk = ~clk;

  rv_trigger_unit #(.NumTriggers(4), .Width(32), .CountWidth(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_write(csr_write),
    .csr_rdata(csr_rdata), .csr_sel(csr_sel),
    .debug_mode(debug_mode), .pc(pc), .pc_valid(pc_valid),
    .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
    .retire(retire), .breakpoint(breakpoint), .debug_req(debug_req),
    .hit_idx(hit_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_write = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #2;
    d = csr_rdata;
    step();
  endtask

  task automatic sample_fire();
    #2;
    fv = {breakpoint, debug_req, hit_idx};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; csr_addr = '0; csr_wdata = '0; csr_write = 1'b0;
    debug_mode = 1'b0; pc = '0; pc_valid = 1'b1; mem_addr = '0;
    mem_load = 1'b0; mem_store = 1'b0; retire = 1'b0;
    step(); step();
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL reset_fire got=%b want=000000", fv); end
    step();
    rst_n = 1'b1; pc_valid = 1'b0;
    csr_rd(A_TSEL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tselect got=%h want=0", rd); end
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tdata1 got=%h want=0", rd); end
    csr_rd(A_TD2, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tdata2 got=%h want=0", rd); end
    csr_wr(A_TINF, 32'hFFFF_FFFF);
    csr_rd(A_TINF, rd);
    total++; if (rd !== 32'h0000_000C) begin bad++; $display("FAIL tinfo got=%h want=0000000c", rd); end
    csr_addr = 12'h300;
    #2;
    total++; if ({csr_sel, csr_rdata} !== 33'h0) begin bad++; $display("FAIL unsel_read got=%b/%h want=0/0", csr_sel, csr_rdata); end
    step();
    csr_wr(A_TSEL, 32'd4);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h3000_0000) begin bad++; $display("FAIL reset_icount got=%h want=30000000", rd); end
  endtask

  task automatic test_execute();
    csr_wr(A_TSEL, 32'd0);
    csr_wr(A_TD2, 32'h100);
    csr_wr(A_TD1, 32'h2000_0004);
    pc = 32'h100; pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b100000) begin bad++; $display("FAIL exec_fire got=%b want=100000", fv); end
    step();
    pc_valid = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2010_0004) begin bad++; $display("FAIL exec_hit got=%h want=20100004", rd); end
    pc = 32'h104; pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL exec_miss got=%b want=000000", fv); end
    step();
    pc_valid = 1'b0;
  endtask

  task automatic test_chain();
    csr_wr(A_TSEL, 32'd0);
    csr_wr(A_TD2, 32'h2000);
    csr_wr(A_TD1, 32'h2000_0902);
    csr_wr(A_TSEL, 32'd1);
    csr_wr(A_TD2, 32'h3000);
    csr_wr(A_TD1, 32'h2000_1182);
    mem_addr = 32'h2800; mem_store = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b010001) begin bad++; $display("FAIL chain_fire got=%b want=010001", fv); end
    step();
    mem_addr = 32'h3800;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL chain_hi got=%b want=000000", fv); end
    step();
    mem_store = 1'b0; mem_addr = 32'h2800; mem_load = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL chain_load got=%b want=000000", fv); end
    step();
    mem_load = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2010_1182) begin bad++; $display("FAIL chain_hit1 got=%h want=20101182", rd); end
    csr_wr(A_TSEL, 32'd0);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2000_0902) begin bad++; $display("FAIL chain_hit0 got=%h want=20000902", rd); end
  endtask

  task automatic test_priority();
    csr_wr(A_TSEL, 32'd0);
    csr_wr(A_TD1, 32'h0);
    csr_wr(A_TSEL, 32'd1);
    csr_wr(A_TD2, 32'h40);
    csr_wr(A_TD1, 32'h2000_0004);
    csr_wr(A_TSEL, 32'd2);
    csr_wr(A_TD2, 32'h40);
    csr_wr(A_TD1, 32'h2000_0004);
    pc = 32'h40; pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b100001) begin bad++; $display("FAIL prio_fire got=%b want=100001", fv); end
    step();
    pc_valid = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2010_0004) begin bad++; $display("FAIL prio_hit2 got=%h want=20100004", rd); end
    csr_wr(A_TSEL, 32'd1);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2010_0004) begin bad++; $display("FAIL prio_hit1 got=%h want=20100004", rd); end
  endtask

  task automatic test_icount();
    pc = 32'h200;
    csr_wr(A_TSEL, 32'd4);
    csr_wr(A_TD1, 32'h3000_0C00);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h3000_0C00) begin bad++; $display("FAIL ic_cfg got=%h want=30000c00", rd); end
    retire = 1'b1;
    step(); step(); step();
    retire = 1'b0;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL ic_early got=%b want=000000", fv); end
    step();
    pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b100100) begin bad++; $display("FAIL ic_fire got=%b want=100100", fv); end
    step();
    pc_valid = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h3100_0000) begin bad++; $display("FAIL ic_hit got=%h want=31000000", rd); end
    pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL ic_once got=%b want=000000", fv); end
    step();
    pc_valid = 1'b0;
    csr_wr(A_TD1, 32'h3000_0400);
    csr_addr = A_TD1; csr_wdata = 32'h3000_1400; csr_write = 1'b1; retire = 1'b1;
    step();
    csr_write = 1'b0; retire = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h3000_1400) begin bad++; $display("FAIL ic_wr_prio got=%h want=30001400", rd); end
    pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL ic_no_pend got=%b want=000000", fv); end
    step();
    pc_valid = 1'b0;
  endtask

  task automatic test_protect();
    debug_mode = 1'b1;
    csr_wr(A_TSEL, 32'd0);
    csr_wr(A_TD2, 32'h11);
    csr_wr(A_TD1, 32'h2800_0004);
    debug_mode = 1'b0;
    csr_wr(A_TD2, 32'h55);
    csr_rd(A_TD2, rd);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL prot_td2 got=%h want=00000011", rd); end
    csr_wr(A_TD1, 32'h0);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2800_0004) begin bad++; $display("FAIL prot_td1 got=%h want=28000004", rd); end
    debug_mode = 1'b1;
    pc = 32'h11; pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL dbg_suppress got=%b want=000000", fv); end
    step();
    debug_mode = 1'b0;
    sample_fire();
    total++; if (fv !== 6'b100000) begin bad++; $display("FAIL dbg_exit_fire got=%b want=100000", fv); end
    step();
    pc_valid = 1'b0;
    csr_wr(A_TSEL, 32'd3);
    csr_wr(A_TD1, 32'h2800_0000);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2000_0000) begin bad++; $display("FAIL dmode_nodbg got=%h want=20000000", rd); end
  endtask

  task automatic test_warl_reset();
    csr_wr(A_TSEL, 32'd2);
    csr_wr(A_TSEL, 32'd9);
    csr_rd(A_TSEL, rd);
    total++; if (rd !== 32'd2) begin bad++; $display("FAIL tsel_warl got=%h want=00000002", rd); end
    csr_wr(A_TSEL, 32'd4);
    csr_rd(A_TSEL, rd);
    total++; if (rd !== 32'd4) begin bad++; $display("FAIL tsel_max got=%h want=00000004", rd); end
    csr_wr(A_TSEL, 32'd3);
    csr_wr(A_TD1, 32'h5000_0080);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL field_sanit got=%h want=0", rd); end
    csr_wr(A_TD1, 32'h2000_2800);
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h2000_0000) begin bad++; $display("FAIL last_chain got=%h want=20000000", rd); end
    csr_wr(A_TSEL, 32'd4);
    csr_wr(A_TD1, 32'h3000_0400);
    retire = 1'b1;
    step();
    retire = 1'b0;
    csr_rd(A_TD1, rd);
    total++; if (rd !== 32'h3000_0000) begin bad++; $display("FAIL pend_count got=%h want=30000000", rd); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pc = 32'h300; pc_valid = 1'b1;
    sample_fire();
    total++; if (fv !== 6'b000000) begin bad++; $display("FAIL reset_pend got=%b want=000000", fv); end
    step();
    pc_valid = 1'b0;
    csr_rd(A_TSEL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_tsel2 got=%h want=0", rd); end
  endtask

  initial begin
    test_reset();
    test_execute();
    test_chain();
    test_priority();
    test_icount();
    test_protect();
    test_warl_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_trigger_unit.md
Name: rv_trigger_unit

Overview:
- Parametrised hardware trigger module for the multi-cycle RV32 core.
- Drives the core's `breakpoint` input to the interrupt controller, replacing the tied-off input.
- Provides N address/data-address match triggers with chaining, plus one instruction-count trigger. Configured through the Sdtrig-style CSRs tselect/tdata1/tdata2/tinfo.
- Sits beside the csr block and shares its CSR address/write/data signalling.

Parameters:
- NumTriggers, 4, number of match triggers (1..15); index NumTriggers is the icount trigger.
- Width, 32, XLEN of addresses and CSR data.
- CountWidth, 14, width of the icount counter field.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- csr_addr  in  12  CSR address from the decoded instruction immediate
- csr_wdata  in  Width  final CSR write value (after RW/RS/RC resolution in csr)
- csr_write  in  1  CSR write strobe, one cycle
- csr_rdata  out  Width  read data for csr_addr (combinational)
- csr_sel  out  1  csr_addr is one of 0x7A0/0x7A1/0x7A2/0x7A4
- debug_mode  in  1  core is in debug mode
- pc  in  Width  address of instruction about to be fetched
- pc_valid  in  1  fetch of pc starts this cycle
- mem_addr  in  Width  data access address
- mem_load  in  1  load access starts this cycle
- mem_store  in  1  store access starts this cycle
- retire  in  1  instruction retired this cycle
- breakpoint  out  1  trigger fired with action 0 (breakpoint exception)
- debug_req  out  1  trigger fired with action 1 (enter debug)
- hit_idx  out  4  index of the firing trigger, valid when breakpoint or debug_req

Behaviour:
- Reset: tselect=0; all tdata1/tdata2=0 (type 0 = disabled); icount pending=0. breakpoint, debug_req and hit_idx are 0.
- CSR map:
  - tselect 0x7A0: WARL. A write of a value >NumTriggers is ignored.
  - tdata1 0x7A1 and tdata2 0x7A2: address the selected trigger.
  - tinfo 0x7A4: reads 0x0000000C; writes are ignored.
  - csr_rdata is 0 when csr_sel=0.
- Match trigger tdata1 fields:
  - type[31:28]: 2 = match; any other value is stored as 0.
  - dmode[27]; hit[20]; action[15:12] (0 or 1; other values are stored as 0).
  - chain[11]: hardwired 0 on index NumTriggers-1.
  - match[10:7]: 0 = equal, 2 = ≥tdata2, 3 = <tdata2; other values are stored as 0.
  - execute[2], store[1], load[0]. All other bits read 0.
- Icount trigger tdata1 fields (index NumTriggers):
  - type[31:28]=3 fixed.
  - dmode[27]; hit[24].
  - count[CountWidth+9:10]; action[5:0] (0 or 1).
- Write protection: while debug_mode=0, writes to tdata1/tdata2 of a trigger whose dmode=1 are ignored. A dmode bit can only be set while debug_mode=1.
- Match condition, evaluated combinationally each cycle, for trigger i with type 2:
  - (execute & pc_valid & cmp(pc)) | (load & mem_load & cmp(mem_addr)) | (store & mem_store & cmp(mem_addr)).
  - Comparisons are unsigned, full Width.
- Chaining: trigger i with chain=1 only qualifies trigger i+1. i+1 fires only if both match in the same cycle. The fire is reported on the last trigger of the chain. A chained trigger never fires on its own.
- Icount:
  - On retire with debug_mode=0 and count≠0, count decrements at the clock edge.
  - A 1→0 transition sets pending.
  - The trigger fires on the next pc_valid with pending=1; pending clears at that edge.
  - A CSR write to icount tdata1 in the same cycle as retire takes priority: no decrement occurs and pending is cleared.
- Firing:
  - breakpoint/debug_req are combinational in the same cycle as the qualifying pc_valid/mem_*, for same-cycle use by int_ctl.
  - When several triggers fire, the lowest index wins; hit_idx and the action come from that trigger. Only one of breakpoint/debug_req is asserted.
  - All firing is suppressed while debug_mode=1.
- Hit bits: set at the clock edge for every firing trigger, including ones that lost priority. They clear only by a CSR write.
- Reset mid-operation: everything returns to reset state at the next edge. No pending fire survives reset.

Test Plan:
- Execute match: tselect=0, tdata2=0x100, tdata1=0x20000004 (type 2, execute, action 0); pc=0x100 with pc_valid → breakpoint=1, hit_idx=0 in that cycle, tdata1 reads 0x20100004 afterwards. pc=0x104 → no fire.
- Chain plus range on stores:
  - Trigger 0 setup: ≥0x2000, store, chain=1.
  - Trigger 1 setup: <0x3000, store, action 1.
  - Store to 0x2800 → debug_req=1, hit_idx=1.
  - Store to 0x3800 → no fire.
  - Load to 0x2800 → no fire.
- Icount: count=3, action 0; three retires → pending. The next pc_valid fires breakpoint with hit_idx=4; count reads 0 and hit=1.
- Priority: triggers 1 and 2 both execute-match pc=0x40 → hit_idx=1, and both hit bits are set.
- Protection and suppression:
  - In debug_mode, set dmode on trigger 0. Leave debug; a write of tdata2=0x55 is ignored and still reads the old value.
  - With debug_mode=1 and a matching pc → no fire.
- WARL: write tselect=9 with NumTriggers=4 → still reads the previous value. Reset asserted during pending icount → pending cleared, and no fire on the next pc_valid.
